// File: rtl/mem_cmd_pkg.sv
// Shared types and constants for the byte-serial memory command front-end.
package mem_cmd_pkg;

   localparam int DATA_W       = 16;
   localparam int CMD_WR_BIT   = 7;
   localparam int CMD_INC_BIT  = 6;
   localparam int ADDR_FIELD_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      GET_HI,
      GET_LO,
      WRITE,
      RD_WAIT,
      SEND_HI,
      SEND_LO
   } state_t;

endpackage

// File: rtl/rd_lat_cnt.sv
// Read-latency down-counter: loaded with RD_LAT, done while the count is zero.
module rd_lat_cnt #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic done
);

   logic [1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= 2'(RD_LAT);
      end else if (cnt != '0) begin
         cnt <= cnt - 2'd1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/mem_cmd_frontend.sv
// Byte-serial command front-end: assembles 16-bit word writes/reads for the word memory.
// Optional MEM_CMD_AUTOINC_EN: command bit6 selects addr_q+1 instead of the address field.
module mem_cmd_frontend
   import mem_cmd_pkg::*;
#(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = mem_cmd_pkg::DATA_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [ADDR_W-1:0]   next_addr;
   logic                in_xfer;
   logic                cnt_load;
   logic                cnt_done;
   logic                unused_cmd_bits;

   // Reserved and out-of-range command bits are deliberately ignored.
   assign unused_cmd_bits = ^in_byte;

`ifdef MEM_CMD_AUTOINC_EN
   assign next_addr = in_byte[CMD_INC_BIT] ? addr_q + 1'b1 : in_byte[ADDR_W-1:0];
`else
   assign next_addr = in_byte[ADDR_W-1:0];
`endif

   always_comb begin
      in_ready = 1'b0;
      case (state)
         IDLE, GET_HI, GET_LO: in_ready = 1'b1;
         default:              in_ready = 1'b0;
      endcase
   end

   assign in_xfer   = in_valid && in_ready;
   assign cnt_load  = (state == IDLE) && in_xfer && !in_byte[CMD_WR_BIT];
   assign busy      = (state != IDLE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   rd_lat_cnt #(.RD_LAT(RD_LAT)) u_rd_lat_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .done (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         mem_we    <= 1'b0;
         out_valid <= 1'b0;
         out_byte  <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: if (in_xfer) begin
               addr_q <= next_addr;
               state  <= in_byte[CMD_WR_BIT] ? GET_HI : RD_WAIT;
            end
            GET_HI: if (in_xfer) begin
               wdata_q[DATA_W-1:8] <= in_byte;
               state               <= GET_LO;
            end
            // mem_we is registered here so it is high for exactly the WRITE cycle.
            GET_LO: if (in_xfer) begin
               wdata_q[7:0] <= in_byte;
               mem_we       <= 1'b1;
               state        <= WRITE;
            end
            WRITE: state <= IDLE;
            RD_WAIT: if (cnt_done) begin
               rdata_q   <= mem_rdata;
               out_byte  <= mem_rdata[DATA_W-1:8];
               out_valid <= 1'b1;
               state     <= SEND_HI;
            end
            SEND_HI: if (out_ready) begin
               out_byte <= rdata_q[7:0];
               state    <= SEND_LO;
            end
            SEND_LO: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_cmd_frontend.sv
// Directed self-checking bench for mem_cmd_frontend with a 1-cycle-latency word memory model.
module tb_mem_cmd_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        busy;

   logic [15:0] mem [8];
   int          we_cnt = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   mem_cmd_frontend #(.ADDR_W(3), .DATA_W(16), .RD_LAT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_byte   (in_byte),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Registered-read word memory: data appears one cycle after the address.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a byte at the falling edge, return at the falling edge after it is accepted.
   task automatic push(input logic [7:0] b);
      int n;
      in_byte  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("push_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      rst       = 1'b1;
      in_byte   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick(2);
      rst = 1'b0;

      // Reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_byte", out_byte, 8'h00);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);

      // 1: write 0x1253 to addr 7
      push(8'h87);
      check("wr_busy_hi", busy, 1);
      push(8'h12);
      push(8'h53);
      in_valid = 1'b0;
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, 7);
      check("wr_data", mem_wdata, 16'h1253);
      check("wr_in_ready_lo", in_ready, 0);
      tick(1);
      check("wr_we_pulse_end", mem_we, 0);
      check("wr_busy_lo", busy, 0);
      check("wr_count", we_cnt, 1);

      // 2: read addr 7, first byte appears RD_LAT+1 cycles after the command
      push(8'h07);
      in_valid = 1'b0;
      check("rd_wait1_ov", out_valid, 0);
      check("rd_wait_in_ready", in_ready, 0);
      tick(1);
      check("rd_wait2_ov", out_valid, 0);
      tick(1);
      check("rd_hi_ov", out_valid, 1);
      check("rd_hi_byte", out_byte, 8'h12);
      tick(1);
      check("rd_lo_ov", out_valid, 1);
      check("rd_lo_byte", out_byte, 8'h53);
      tick(1);
      check("rd_done_ov", out_valid, 0);
      check("rd_done_busy", busy, 0);
      check("rd_no_we", we_cnt, 1);

      // 3: back-pressure on a read of 0xBEEF at addr 3
      push(8'h83);
      push(8'hBE);
      push(8'hEF);
      in_valid = 1'b0;
      tick(1);
      out_ready = 1'b0;
      push(8'h03);
      in_valid = 1'b0;
      tick(2);
      for (int i = 0; i < 5; i++) begin
         check("bp_ov", out_valid, 1);
         check("bp_byte", out_byte, 8'hBE);
         check("bp_in_ready", in_ready, 0);
         tick(1);
      end
      out_ready = 1'b1;
      tick(1);
      check("bp_lo_byte", out_byte, 8'hEF);
      check("bp_lo_ov", out_valid, 1);
      tick(1);
      check("bp_done_ov", out_valid, 0);

      // 4: reset during a partial write drops it
      push(8'h82);
      push(8'hAA);
      in_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rstw_in_ready", in_ready, 1);
      check("rstw_busy", busy, 0);
      check("rstw_addr", mem_addr, 0);
      check("rstw_wdata", mem_wdata, 16'h0000);
      tick(3);
      check("rstw_no_we", we_cnt, 2);
      push(8'h81);
      push(8'h00);
      push(8'h01);
      in_valid = 1'b0;
      check("rstw_we", mem_we, 1);
      check("rstw_addr2", mem_addr, 1);
      check("rstw_data2", mem_wdata, 16'h0001);
      tick(1);

      // Reset during a stalled read response discards it
      out_ready = 1'b0;
      push(8'h07);
      in_valid = 1'b0;
      tick(2);
      check("rstr_ov_pre", out_valid, 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rstr_ov", out_valid, 0);
      check("rstr_byte", out_byte, 8'h00);
      check("rstr_busy", busy, 0);
      out_ready = 1'b1;

      // 5: address field truncated to ADDR_W bits
      push(8'h8F);
      push(8'h00);
      push(8'h00);
      in_valid = 1'b0;
      check("trunc_we", mem_we, 1);
      check("trunc_addr", mem_addr, 7);
      check("trunc_data", mem_wdata, 16'h0000);
      tick(1);

      // 6: auto-increment (addr_q is 7 here) vs explicit address field
      push(8'hC0);
      push(8'h11);
      push(8'h22);
      in_valid = 1'b0;
      check("inc_wrap_addr", mem_addr, 0);
      check("inc_wrap_data", mem_wdata, 16'h1122);
      tick(1);
      push(8'hC5);
      push(8'h33);
      push(8'h44);
      in_valid = 1'b0;
`ifdef MEM_CMD_AUTOINC_EN
      check("inc_next_addr", mem_addr, 1);
`else
      check("inc_next_addr", mem_addr, 5);
`endif
      check("inc_next_data", mem_wdata, 16'h3344);
      tick(1);
      check("final_we_count", we_cnt, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_cmd_frontend.md
Name: mem_cmd_frontend

Overview:
- Byte-serial command front-end placed directly upstream of the DFF word memory (tt_um_mem core).
- Assembles 8-bit command/data bytes from the pad interface into 16-bit word writes and reads on the memory's addr/we/data port.
- Serialises read data back out as bytes.
- Replaces testbench-forced addr/we with a real control path.

Parameters:
- ADDR_W, 3: memory address width; maximum 4.
- DATA_W, 16: memory word width; fixed at 2 bytes.
- RD_LAT, 1: cycles from mem_addr valid to mem_rdata valid; legal range 0..3.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_byte  in  8  command/data byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  front-end accepts in_byte this cycle.
- out_byte  out  8  read-data byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write strobe, one-cycle pulse.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Byte transfer: occurs when in_valid && in_ready. Output transfer: occurs when out_valid && out_ready.
- Command byte:
  - bit7 = 1 for write, 0 for read.
  - bit6 = auto-increment request (see Optional Feature).
  - bits5:4 are reserved and ignored.
  - bits3:0 carry the address; only the low ADDR_W bits are used.
- FSM states: IDLE, GET_HI, GET_LO, WRITE, RD_WAIT, SEND_HI, SEND_LO.
  - IDLE: in_ready=1. On command byte, latch addr_q. Write goes to GET_HI. Read goes to RD_WAIT, with wait counter loaded to RD_LAT.
  - GET_HI: in_ready=1. On byte, wdata_q[15:8] <= in_byte; go to GET_LO.
  - GET_LO: in_ready=1. On byte, wdata_q[7:0] <= in_byte; go to WRITE.
  - WRITE: in_ready=0. Drive mem_we=1 for exactly this cycle, with mem_addr=addr_q and mem_wdata=wdata_q. Go to IDLE.
  - RD_WAIT: in_ready=0. Counter decrements each cycle. When it is 0, capture mem_rdata into rdata_q and go to SEND_HI. With RD_LAT=0, capture occurs in the first RD_WAIT cycle.
  - SEND_HI: out_valid=1, out_byte=rdata_q[15:8]. On transfer, go to SEND_LO.
  - SEND_LO: out_valid=1, out_byte=rdata_q[7:0]. On transfer, go to IDLE.
- Timing:
  - Write latency: mem_we asserts exactly 1 cycle after the low data byte is accepted.
  - Read latency: first out_valid asserts RD_LAT+1 cycles after the command byte is accepted.
- mem_addr always equals addr_q (registered output, no glitching). mem_we is 0 in every state except WRITE.
- Handshake rules:
  - out_byte is held stable while out_valid && !out_ready.
  - in_ready is combinational from state only; it never depends on in_valid.
- Back-pressure: out_ready held low stalls indefinitely in SEND_*. No new command is accepted until both bytes are sent.
- A partial write (command or hi byte received, then the stream stops) waits indefinitely. Only rst aborts it; no memory write occurs.
- Reset values, applied mid-operation or otherwise:
  - State: IDLE.
  - Registers: addr_q=0, wdata_q=0, rdata_q=0.
  - Outputs: mem_we=0, out_valid=0, out_byte=0, in_ready=1 (after reset cycle), busy=0.
  - A write in progress is dropped. A read response in progress is discarded.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_CMD_AUTOINC_EN.
- Defined:
  - Command bit6=1 ignores bits3:0 and uses addr_q+1, wrapping modulo 2^ADDR_W (7 -> 0 for ADDR_W=3).
  - addr_q is retained across commands. Reset still clears addr_q to 0.
  - Bit6=0 behaves as the normal explicit address.
- Not defined: bit6 is ignored and the address always comes from bits3:0.

Decomposition:
- Shared package mem_cmd_pkg holds:
  - State enum.
  - Command-bit constants: CMD_WR_BIT=7, CMD_INC_BIT=6, ADDR_FIELD_W=4.
  - DATA_W localparam.
- Sub-module rd_lat_cnt: small down-counter loaded with RD_LAT, producing a done flag. The FSM lives in the top module.

Test Plan:
1. Write: bytes 0x87, 0x12, 0x53 with in_valid continuous -> one-cycle mem_we with mem_addr=7, mem_wdata=0x1253, 1 cycle after byte 0x53 is accepted. busy returns low the next cycle.
2. Read: memory model (RD_LAT=1) holds 0x1253 at addr 7; send 0x07 -> out_byte 0x12 then 0x53, with out_ready=1. No mem_we during the read.
3. Back-pressure: read of addr 3 (data 0xBEEF) with out_ready=0 for 5 cycles -> out_byte held at 0xBE with out_valid=1 and in_ready=0. Then 0xBE, 0xEF transfer.
4. Reset mid-operation: send 0x82, 0xAA, then assert rst one cycle -> no mem_we ever. State is IDLE and in_ready=1. A following write of 0x81, 0x00, 0x01 writes 0x0001 to addr 1.
5. Address truncation: command 0x8F with data 0x0000 -> mem_addr=7 (low 3 bits) for ADDR_W=3.
6. With MEM_CMD_AUTOINC_EN: write to addr 7, then commands 0xC0, 0x11, 0x22 -> mem_addr=0 (wrap), wdata 0x1122. Without the macro, the same bytes write addr 0 via the explicit field.
